cp0_irq_ctrl: RTL and testbench
===============================

Name: cp0_irq_ctrl

Overview:
- Write-back-stage CP0 and interrupt controller.
- Consumes the CP0 control fields delivered by the DM/WB pipeline register: IE/EPC write enables, CP0 op, store-data operand, PC+4 and halt.
- Owns IE, EPC, pending and in-service state, and latches external interrupt requests.
- Issues a one-cycle PC redirect plus pipeline flush on interrupt entry and on ERET.

Parameters:
- NUM_IRQ, 3, number of external interrupt lines; index 0 has highest priority.
- VEC_BASE, 32'h0000_0800, handler address for IRQ 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between consecutive handler vectors.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-high (rst_n=1 resets on the clk edge).
- en  in  1  pipeline advance; WB instruction retires only when en=1.
- wb_valid  in  1  WB slot holds a real (non-bubble) instruction.
- halt_dm_wb  in  1  halt instruction in WB.
- w_en_ie_dm_wb  in  1  MTC0 targets IE.
- w_en_epc_dm_wb  in  1  MTC0 targets EPC.
- op_cp0_dm_wb  in  2  00 none, 01 MFC0, 10 MTC0, 11 ERET.
- regfile_data_b_dm_wb  in  32  MTC0 write data.
- pc_4_dm_wb  in  32  PC+4 of the WB instruction.
- cp0_rsel  in  2  MFC0 read select: 0 IE, 1 EPC, 2 pending, 3 in_service.
- irq_in  in  NUM_IRQ  external requests, already synchronous to clk.
- cp0_rdata  out  32  combinational MFC0 read data, zero-extended.
- ie_out  out  1  global interrupt enable.
- epc_out  out  32  EPC register.
- pending_out  out  NUM_IRQ  latched pending requests.
- in_service  out  NUM_IRQ  one-hot IRQ being serviced, else 0.
- redirect  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  target PC, valid while redirect=1.
- flush  out  1  one-cycle flush of IF/ID/EX/DM; identical timing to redirect.

Behaviour:
- Reset values: IE=0, EPC=0, pending=0, in_service=0, irq_prev=0, redirect=0, redirect_pc=0, flush=0, state=IDLE. Reset has priority over every other event, including mid-service and mid-redirect.
- Retire condition: retire = en & wb_valid & ~halt_dm_wb. All CP0 writes, entry and ERET require retire=1.
- Request capture: each rising edge of irq_in[i] (irq_in & ~irq_prev) sets pending[i]. Level-high without a new edge sets nothing.
- States: IDLE, SERVICE.
- IDLE to SERVICE (entry) when retire & IE & |pending, evaluated on registered IE and pending. On entry:
  - k = lowest set index of pending.
  - EPC <= pc_4_dm_wb (the WB instruction completes; it is not replayed).
  - IE <= 0; in_service <= onehot(k).
  - Next cycle: redirect=1, flush=1, redirect_pc = VEC_BASE + k*VEC_STRIDE (mod 2^32), for exactly one cycle.
- Entry and an MTC0 in the same WB instruction: the MTC0 write is applied, then the entry updates override the IE and EPC fields they touch.
- In SERVICE: no nesting; new edges still latch into pending, but entry is blocked even if MTC0 sets IE=1.
- ERET (op=11 with retire):
  - Next cycle: redirect=1, flush=1, redirect_pc = EPC value at the ERET edge.
  - IE <= 1.
  - In SERVICE: clear pending bit of in_service, in_service <= 0, state <= IDLE.
  - In IDLE: redirect still occurs; pending is untouched.
- Clear vs. new request: if the in_service bit's clear coincides with a new edge on the same line, set wins and the bit stays pending.
- MTC0 (op=10 with retire): IE <= data[0] if w_en_ie; EPC <= data if w_en_epc. Both may be written in the same cycle. The new value is visible the following cycle.
- Redirect spacing: redirect can never be asserted two cycles in a row. The cycle with redirect=1 flushes WB, so retire=0 in practice.
- MFC0 has no side effects. cp0_rdata = IE / EPC / pending / in_service per cp0_rsel.

Test Plan:
- Reset: rst_n=1 for 2 cycles while irq_in toggles -> all outputs 0, IDLE; then reset mid-SERVICE -> in_service=0, IE=0, redirect stays 0.
- Basic entry: MTC0 IE=1, then irq_in[1] edge, retire with pc_4=32'h0000_0104 -> next cycle redirect=flush=1 for one cycle, redirect_pc=32'h0000_0810; EPC=32'h104, IE=0, in_service=3'b010.
- Priority: irq_in[2] and irq_in[0] edges in the same cycle, IE=1 -> vector 32'h0000_0800, in_service=3'b001, pending[2] remains 1.
- ERET return: in SERVICE issue ERET -> next cycle redirect_pc=32'h104, IE=1, pending[0] cleared, IDLE; pending[2] entry follows on the next retire, vector 32'h0000_0820.
- Blocked entry: pending set with en=0, halt_dm_wb=1, or wb_valid=0 -> no redirect; in SERVICE an MTC0 IE=1 plus a new edge on irq_in[1] -> no entry until after ERET.
- Clear/set race: a new edge on the in_service line coincides with ERET -> bit stays pending; after return, re-entry to the same vector.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// Write-back-stage CP0 register file and interrupt controller.
// Holds IE, EPC, pending and in-service state. It takes interrupts on a retiring
// WB instruction and returns from them on ERET. In both cases it issues a
// registered one-cycle redirect and flush.
module cp0_irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               wb_valid,
    input  logic               halt_dm_wb,
    input  logic               w_en_ie_dm_wb,
    input  logic               w_en_epc_dm_wb,
    input  logic [1:0]         op_cp0_dm_wb,
    input  logic [31:0]        regfile_data_b_dm_wb,
    input  logic [31:0]        pc_4_dm_wb,
    input  logic [1:0]         cp0_rsel,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [31:0]        cp0_rdata,
    output logic               ie_out,
    output logic [31:0]        epc_out,
    output logic [NUM_IRQ-1:0] pending_out,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               flush
);

    typedef enum logic [0:0] {StIdle, StService} state_e;

    localparam logic [1:0] OpMtc0 = 2'b10;
    localparam logic [1:0] OpEret = 2'b11;

    state_e             state_q, state_d;
    logic               ie_q, ie_d;
    logic [31:0]        epc_q, epc_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    logic               retire;
    logic               do_mtc0;
    logic               do_eret;
    logic               do_entry;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [31:0]        irq_idx;
    logic [NUM_IRQ-1:0] irq_onehot;

    // Priority pick of the lowest pending line and the retire/event decode
    always_comb begin
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                irq_idx       = 32'(i);
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
        retire   = en & wb_valid & ~halt_dm_wb;
        irq_edge = irq_in & ~irq_prev_q;
        do_mtc0  = retire && (op_cp0_dm_wb == OpMtc0);
        // A redirect cycle never starts another redirect; the WB slot is flushed anyway.
        do_entry = retire && !redirect_q && (state_q == StIdle) && ie_q && (|pending_q);
        do_eret  = retire && !redirect_q && (op_cp0_dm_wb == OpEret) && !do_entry;
    end

    // Next-state for CP0 registers, service state and redirect strobe
    always_comb begin
        state_d       = state_q;
        ie_d          = ie_q;
        epc_d         = epc_q;
        pending_d     = pending_q;
        in_service_d  = in_service_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;

        if (do_mtc0) begin
            if (w_en_ie_dm_wb) begin
                ie_d = regfile_data_b_dm_wb[0];
            end
            if (w_en_epc_dm_wb) begin
                epc_d = regfile_data_b_dm_wb;
            end
        end

        if (do_entry) begin
            // Entry overrides any MTC0 write carried by the same instruction.
            ie_d          = 1'b0;
            epc_d         = pc_4_dm_wb;
            in_service_d  = irq_onehot;
            state_d       = StService;
            redirect_d    = 1'b1;
            redirect_pc_d = VEC_BASE + irq_idx * VEC_STRIDE;
        end else if (do_eret) begin
            ie_d          = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = epc_q;
            if (state_q == StService) begin
                pending_d    = pending_q & ~in_service_q;
                in_service_d = '0;
                state_d      = StIdle;
            end
        end

        // New edges are applied last so a simultaneous set beats the ERET clear.
        pending_d = pending_d | irq_edge;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= StIdle;
            ie_q          <= 1'b0;
            epc_q         <= '0;
            pending_q     <= '0;
            in_service_q  <= '0;
            irq_prev_q    <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            ie_q          <= ie_d;
            epc_q         <= epc_d;
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            irq_prev_q    <= irq_in;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // MFC0 read mux, zero-extended
    always_comb begin
        cp0_rdata = '0;
        unique case (cp0_rsel)
            2'd0: cp0_rdata[0]           = ie_q;
            2'd1: cp0_rdata              = epc_q;
            2'd2: cp0_rdata[NUM_IRQ-1:0] = pending_q;
            2'd3: cp0_rdata[NUM_IRQ-1:0] = in_service_q;
            default: cp0_rdata = '0;
        endcase
    end

    assign ie_out      = ie_q;
    assign epc_out     = epc_q;
    assign pending_out = pending_q;
    assign in_service  = in_service_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = redirect_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed, table-driven bench for cp0_irq_ctrl: each row drives one cycle of
// inputs and lists the register state expected right after that clock edge.
module tb_cp0_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wb_valid;
    logic        halt_dm_wb;
    logic        w_en_ie_dm_wb;
    logic        w_en_epc_dm_wb;
    logic [1:0]  op_cp0_dm_wb;
    logic [31:0] regfile_data_b_dm_wb;
    logic [31:0] pc_4_dm_wb;
    logic [1:0]  cp0_rsel;
    logic [2:0]  irq_in;
    logic [31:0] cp0_rdata;
    logic        ie_out;
    logic [31:0] epc_out;
    logic [2:0]  pending_out;
    logic [2:0]  in_service;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_irq_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .en                   (en),
        .wb_valid             (wb_valid),
        .halt_dm_wb           (halt_dm_wb),
        .w_en_ie_dm_wb        (w_en_ie_dm_wb),
        .w_en_epc_dm_wb       (w_en_epc_dm_wb),
        .op_cp0_dm_wb         (op_cp0_dm_wb),
        .regfile_data_b_dm_wb (regfile_data_b_dm_wb),
        .pc_4_dm_wb           (pc_4_dm_wb),
        .cp0_rsel             (cp0_rsel),
        .irq_in               (irq_in),
        .cp0_rdata            (cp0_rdata),
        .ie_out               (ie_out),
        .epc_out              (epc_out),
        .pending_out          (pending_out),
        .in_service           (in_service),
        .redirect             (redirect),
        .redirect_pc          (redirect_pc),
        .flush                (flush)
    );

    typedef struct {
        logic        rst, en, v, h, wie, wepc;
        logic [1:0]  op;
        logic [31:0] data, pc4;
        logic [1:0]  rsel;
        logic [2:0]  irq;
        logic        e_ie;
        logic [31:0] e_epc;
        logic [2:0]  e_pend, e_insv;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tbl[$];
    vec_t seq[$];

    function automatic vec_t mk(logic rst, logic e, logic v, logic h, logic wie, logic wepc,
                                logic [1:0] op, logic [31:0] data, logic [31:0] pc4,
                                logic [1:0] rsel, logic [2:0] irq, logic e_ie,
                                logic [31:0] e_epc, logic [2:0] e_pend, logic [2:0] e_insv,
                                logic e_redir, logic [31:0] e_rpc);
        vec_t r;
        r.rst = rst; r.en = e; r.v = v; r.h = h; r.wie = wie; r.wepc = wepc;
        r.op = op; r.data = data; r.pc4 = pc4; r.rsel = rsel; r.irq = irq;
        r.e_ie = e_ie; r.e_epc = e_epc; r.e_pend = e_pend; r.e_insv = e_insv;
        r.e_redir = e_redir; r.e_rpc = e_rpc;
        return r;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(vec_t r, int row);
        logic [31:0] e_rd;
        rst_n                = r.rst;
        en                   = r.en;
        wb_valid             = r.v;
        halt_dm_wb           = r.h;
        w_en_ie_dm_wb        = r.wie;
        w_en_epc_dm_wb       = r.wepc;
        op_cp0_dm_wb         = r.op;
        regfile_data_b_dm_wb = r.data;
        pc_4_dm_wb           = r.pc4;
        cp0_rsel             = r.rsel;
        irq_in               = r.irq;
        @(posedge clk);
        #1;
        case (r.rsel)
            2'd0:    e_rd = {31'b0, r.e_ie};
            2'd1:    e_rd = r.e_epc;
            2'd2:    e_rd = {29'b0, r.e_pend};
            default: e_rd = {29'b0, r.e_insv};
        endcase
        chk("ie", row, {31'b0, ie_out}, {31'b0, r.e_ie});
        chk("epc", row, epc_out, r.e_epc);
        chk("pending", row, {29'b0, pending_out}, {29'b0, r.e_pend});
        chk("in_service", row, {29'b0, in_service}, {29'b0, r.e_insv});
        chk("redirect", row, {31'b0, redirect}, {31'b0, r.e_redir});
        chk("flush", row, {31'b0, flush}, {31'b0, r.e_redir});
        chk("cp0_rdata", row, cp0_rdata, e_rd);
        if (r.e_redir) chk("redirect_pc", row, redirect_pc, r.e_rpc);
    endtask

    initial begin
        // rst en v h wie wepc op data pc4 rsel irq | ie epc pend insv redir rpc
        tbl.push_back(mk(1,0,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b101, 0,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(1,1,1,0,1,1,2'd2,32'hFFFF_FFFF,32'h0,2'd1,3'b010,
                         0,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h4,2'd0,3'b000, 0,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,1,0,2'd2,32'h1,32'h8,2'd0,3'b000, 1,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,0,1,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b010, 1,32'h0,3'b010,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b010, 1,32'h0,3'b010,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,1,0,0,2'd0,32'h0,32'h0,2'd2,3'b010, 1,32'h0,3'b010,3'b000,0,32'h0));
        // Basic entry on IRQ 1
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h104,2'd3,3'b010,
                         0,32'h104,3'b010,3'b010,1,32'h810));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd1,3'b000, 0,32'h104,3'b010,3'b010,0,32'h0));
        // In service: MTC0 IE=1 plus a new edge must not nest
        tbl.push_back(mk(0,1,1,0,1,0,2'd2,32'h1,32'h0,2'd0,3'b010, 1,32'h104,3'b010,3'b010,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h104,3'b010,3'b010,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd2,3'b000,
                         1,32'h104,3'b000,3'b000,1,32'h104));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h104,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h104,3'b000,3'b000,0,32'h0));
        // Priority: IRQ 2 and 0 together
        tbl.push_back(mk(0,0,1,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b101, 1,32'h104,3'b101,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h200,2'd3,3'b101,
                         0,32'h200,3'b101,3'b001,1,32'h800));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 0,32'h200,3'b101,3'b001,0,32'h0));
        // ERET racing a new edge on the serviced line: set wins
        tbl.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd2,3'b001,
                         1,32'h200,3'b101,3'b000,1,32'h200));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h200,3'b101,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h300,2'd3,3'b000,
                         0,32'h300,3'b101,3'b001,1,32'h800));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 0,32'h300,3'b101,3'b001,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd2,3'b000,
                         1,32'h300,3'b100,3'b000,1,32'h300));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h300,3'b100,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h400,2'd3,3'b000,
                         0,32'h400,3'b100,3'b100,1,32'h820));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 0,32'h400,3'b100,3'b100,0,32'h0));
        // MTC0 writing IE and EPC together, then ERET to the written EPC
        tbl.push_back(mk(0,1,1,0,1,1,2'd2,32'h1235,32'h0,2'd1,3'b000,
                         1,32'h1235,3'b100,3'b100,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd2,3'b000,
                         1,32'h1235,3'b000,3'b000,1,32'h1235));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h1235,3'b000,3'b000,0,32'h0));
        // ERET while idle still redirects
        tbl.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd0,3'b000,
                         1,32'h1235,3'b000,3'b000,1,32'h1235));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 1,32'h1235,3'b000,3'b000,0,32'h0));
        // Reset in the redirect cycle after an entry
        tbl.push_back(mk(0,0,1,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b010, 1,32'h1235,3'b010,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h500,2'd3,3'b010,
                         0,32'h500,3'b010,3'b010,1,32'h810));
        tbl.push_back(mk(1,1,0,0,0,0,2'd0,32'h0,32'h0,2'd3,3'b000, 0,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 0,32'h0,3'b000,3'b000,0,32'h0));
        // Entry on an instruction that is itself an MTC0 to IE and EPC
        tbl.push_back(mk(0,1,1,0,1,0,2'd2,32'h1,32'h0,2'd0,3'b000, 1,32'h0,3'b000,3'b000,0,32'h0));
        tbl.push_back(mk(0,0,1,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b001, 1,32'h0,3'b001,3'b000,0,32'h0));
        tbl.push_back(mk(0,1,1,0,1,1,2'd2,32'h777,32'h600,2'd1,3'b001,
                         0,32'h600,3'b001,3'b001,1,32'h800));
        tbl.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd0,3'b000, 0,32'h600,3'b001,3'b001,0,32'h0));

        // Redirect spacing: an ERET retiring in the redirect cycle is not honoured,
        // and a level held high sets pending only once.
        seq.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd0,3'b000,
                         1,32'h600,3'b000,3'b000,1,32'h600));
        seq.push_back(mk(0,1,1,0,0,0,2'd3,32'h0,32'h0,2'd2,3'b100, 1,32'h600,3'b100,3'b000,0,32'h0));
        seq.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b100, 1,32'h600,3'b100,3'b000,0,32'h0));
        seq.push_back(mk(0,1,1,0,0,0,2'd0,32'h0,32'h700,2'd3,3'b100,
                         0,32'h700,3'b100,3'b100,1,32'h820));
        seq.push_back(mk(0,1,0,0,0,0,2'd0,32'h0,32'h0,2'd2,3'b100, 0,32'h700,3'b100,3'b100,0,32'h0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        for (int i = 0; i < seq.size(); i++) apply(seq[i], 100 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
